// File: rtl/ahblite_single_master_if.sv
// Bundle of the command/response handshake and the AHB-Lite initiator signals
// for ahblite_single_master. The master modport is the initiator's view and
// the slave modport is the view of whatever sits on the other side.
interface ahblite_single_master_if;
    // command channel
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [1:0]  cmd_size;
    logic [31:0] cmd_wdata;
    // response channel
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    // AHB-Lite bus
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  rsp_ready,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        input  HREADY, HRESP, HRDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output rsp_ready,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        output HREADY, HRESP, HRDATA
    );
endinterface

// File: rtl/ahblite_single_master.sv
// Single-command AHB-Lite initiator: one NONSEQ transfer per accepted command,
// with wait-state/ERROR handling, byte-lane replication/extraction and local
// rejection of illegal or misaligned commands.
//
//  state  | meaning
//  -------+------------------------------------------------------------
//  IDLE   | cmd_ready high, bus idle, waiting for a command
//  ADDR   | NONSEQ address phase, held while HREADY is low
//  DATA   | data phase, counting wait states until HREADY
//  RESP   | response presented, held until rsp_ready
module ahblite_single_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                    i_hclk,
    input  logic                    i_hreset,
    ahblite_single_master_if.master io_bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT_CYCLES);
    localparam logic [1:0]  LP_NONSEQ  = 2'b10;
    localparam logic [1:0]  LP_IDLE    = 2'b00;

    state_t      r_state;
    logic [1:0]  r_htrans;
    logic [31:0] r_haddr;
    logic        r_hwrite;
    logic [2:0]  r_hsize;
    logic [31:0] r_hwdata;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic        r_rsp_timeout;
    logic        r_cmd_ready;
    logic [15:0] r_wait_cnt;

    state_t      w_state_nxt;
    logic [1:0]  w_htrans_nxt;
    logic [31:0] w_haddr_nxt;
    logic        w_hwrite_nxt;
    logic [2:0]  w_hsize_nxt;
    logic [31:0] w_hwdata_nxt;
    logic        w_rsp_valid_nxt;
    logic [31:0] w_rsp_rdata_nxt;
    logic        w_rsp_err_nxt;
    logic        w_rsp_timeout_nxt;
    logic        w_cmd_ready_nxt;
    logic [15:0] w_wait_cnt_nxt;

    logic        w_illegal;
    logic [31:0] w_wdata_repl;
    logic [31:0] w_rdata_lane;

    // Classify the incoming command and pre-build its replicated write data.
    always_comb begin
        w_illegal    = 1'b0;
        w_wdata_repl = io_bus.cmd_wdata;
        case (io_bus.cmd_size)
            2'b00: w_wdata_repl = {4{io_bus.cmd_wdata[7:0]}};
            2'b01: begin
                w_wdata_repl = {2{io_bus.cmd_wdata[15:0]}};
                w_illegal    = io_bus.cmd_addr[0];
            end
            2'b10: w_illegal = (io_bus.cmd_addr[1:0] != 2'b00);
            default: w_illegal = 1'b1;
        endcase
    end

    // Pick the addressed lane of HRDATA for the transfer in flight, zero-extended.
    always_comb begin
        w_rdata_lane = io_bus.HRDATA;
        case (r_hsize[1:0])
            2'b00: begin
                case (r_haddr[1:0])
                    2'b00:   w_rdata_lane = {24'h0, io_bus.HRDATA[7:0]};
                    2'b01:   w_rdata_lane = {24'h0, io_bus.HRDATA[15:8]};
                    2'b10:   w_rdata_lane = {24'h0, io_bus.HRDATA[23:16]};
                    default: w_rdata_lane = {24'h0, io_bus.HRDATA[31:24]};
                endcase
            end
            2'b01: w_rdata_lane = r_haddr[1] ? {16'h0, io_bus.HRDATA[31:16]}
                                             : {16'h0, io_bus.HRDATA[15:0]};
            default: w_rdata_lane = io_bus.HRDATA;
        endcase
    end

    // Next-state and next-value logic for every registered output.
    always_comb begin
        w_state_nxt       = r_state;
        w_htrans_nxt      = LP_IDLE;
        w_haddr_nxt       = r_haddr;
        w_hwrite_nxt      = r_hwrite;
        w_hsize_nxt       = r_hsize;
        w_hwdata_nxt      = r_hwdata;
        w_rsp_valid_nxt   = r_rsp_valid;
        w_rsp_rdata_nxt   = r_rsp_rdata;
        w_rsp_err_nxt     = r_rsp_err;
        w_rsp_timeout_nxt = r_rsp_timeout;
        w_wait_cnt_nxt    = r_wait_cnt;

        case (r_state)
            S_IDLE: begin
                if (io_bus.cmd_valid && r_cmd_ready) begin
                    if (w_illegal) begin
                        w_state_nxt       = S_RESP;
                        w_rsp_valid_nxt   = 1'b1;
                        w_rsp_err_nxt     = 1'b1;
                        w_rsp_rdata_nxt   = 32'h0;
                        w_rsp_timeout_nxt = 1'b0;
                    end else begin
                        w_state_nxt  = S_ADDR;
                        w_htrans_nxt = LP_NONSEQ;
                        w_haddr_nxt  = io_bus.cmd_addr;
                        w_hwrite_nxt = io_bus.cmd_write;
                        w_hsize_nxt  = {1'b0, io_bus.cmd_size};
                        w_hwdata_nxt = w_wdata_repl;
                    end
                end
            end
            S_ADDR: begin
                if (io_bus.HREADY) begin
                    w_state_nxt = S_DATA;
                end else begin
                    w_htrans_nxt = LP_NONSEQ;
                end
            end
            S_DATA: begin
                // The first ERROR cycle arrives with HREADY low and simply counts
                // as a wait; the response is taken on the HREADY-high cycle.
                if (!io_bus.HREADY) begin
                    if (r_wait_cnt != LP_TIMEOUT) begin
                        w_wait_cnt_nxt = r_wait_cnt + 16'd1;
                    end
                end else begin
                    w_state_nxt       = S_RESP;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_err_nxt     = io_bus.HRESP;
                    w_rsp_rdata_nxt   = (!r_hwrite && !io_bus.HRESP) ? w_rdata_lane : 32'h0;
                    w_rsp_timeout_nxt = (r_wait_cnt == LP_TIMEOUT);
                end
            end
            default: begin
                if (io_bus.rsp_ready) begin
                    w_state_nxt     = S_IDLE;
                    w_rsp_valid_nxt = 1'b0;
                    w_wait_cnt_nxt  = 16'h0;
                end
            end
        endcase

        w_cmd_ready_nxt = (w_state_nxt == S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            r_state       <= S_IDLE;
            r_htrans      <= LP_IDLE;
            r_haddr       <= 32'h0;
            r_hwrite      <= 1'b0;
            r_hsize       <= 3'b000;
            r_hwdata      <= 32'h0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= 32'h0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_cmd_ready   <= 1'b1;
            r_wait_cnt    <= 16'h0;
        end else begin
            r_state       <= w_state_nxt;
            r_htrans      <= w_htrans_nxt;
            r_haddr       <= w_haddr_nxt;
            r_hwrite      <= w_hwrite_nxt;
            r_hsize       <= w_hsize_nxt;
            r_hwdata      <= w_hwdata_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_rdata   <= w_rsp_rdata_nxt;
            r_rsp_err     <= w_rsp_err_nxt;
            r_rsp_timeout <= w_rsp_timeout_nxt;
            r_cmd_ready   <= w_cmd_ready_nxt;
            r_wait_cnt    <= w_wait_cnt_nxt;
        end
    end

    assign io_bus.cmd_ready   = r_cmd_ready;
    assign io_bus.rsp_valid   = r_rsp_valid;
    assign io_bus.rsp_rdata   = r_rsp_rdata;
    assign io_bus.rsp_err     = r_rsp_err;
    assign io_bus.rsp_timeout = r_rsp_timeout;
    assign io_bus.HADDR       = r_haddr;
    assign io_bus.HTRANS      = r_htrans;
    assign io_bus.HWRITE      = r_hwrite;
    assign io_bus.HSIZE       = r_hsize;
    assign io_bus.HWDATA      = r_hwdata;
    assign io_bus.HBURST      = 3'b000;
    assign io_bus.HPROT       = 4'b0011;
    assign io_bus.HMASTLOCK   = 1'b0;

endmodule

// File: tb/tb_ahblite_single_master.sv
// Self-checking bench for ahblite_single_master: a directed vector table,
// hand-written reset sequences and random commands against a reference model.
module tb_ahblite_single_master;

    localparam int TO = 16;

    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        int          aw;
        int          dw;
        bit          err;
        logic [31:0] hrdata;
        int          hold;
    } stim_t;

    typedef struct {
        int          lat;
        int          nonseq;
        bit          err;
        logic [31:0] rdata;
        bit          timeout;
        logic [31:0] hwdata;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    logic hclk;
    logic hreset;
    int   n_cmp;
    int   n_fail;

    ahblite_single_master_if bus ();

    ahblite_single_master #(.TIMEOUT_CYCLES(TO)) dut (
        .i_hclk   (hclk),
        .i_hreset (hreset),
        .io_bus   (bus)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit w, input logic [31:0] a, input logic [1:0] sz,
                                input logic [31:0] wd, input int aw, input int dw, input bit er,
                                input logic [31:0] hr, input int hold, input int lat, input int ns,
                                input bit eerr, input logic [31:0] erd, input bit eto,
                                input logic [31:0] ehw);
        vec_t v;
        v.s.write = w;  v.s.addr = a;  v.s.size = sz;  v.s.wdata = wd;
        v.s.aw = aw;    v.s.dw = dw;   v.s.err = er;   v.s.hrdata = hr;  v.s.hold = hold;
        v.e.lat = lat;  v.e.nonseq = ns;  v.e.err = eerr;  v.e.rdata = erd;
        v.e.timeout = eto;  v.e.hwdata = ehw;
        return v;
    endfunction

    // Reference model: derived from transfer size, alignment and slave behaviour.
    function automatic exp_t model(input stim_t s);
        exp_t   e;
        int     nb;
        longint m;
        e.hwdata = 32'h0;
        if (s.size == 2'b11 || (s.addr % (32'd1 << s.size)) != 0) begin
            e.lat = 1;  e.nonseq = 0;  e.err = 1'b1;  e.rdata = 32'h0;  e.timeout = 1'b0;
        end else begin
            nb        = 1 << s.size;
            e.lat     = 3 + s.aw + s.dw;
            e.nonseq  = s.aw + 1;
            e.err     = s.err;
            e.timeout = (s.dw >= TO);
            m         = (64'd1 << (8 * nb)) - 1;
            if (s.write || s.err) e.rdata = 32'h0;
            else e.rdata = 32'((longint'(s.hrdata) >> (8 * (s.addr % 4))) & m);
            if (nb == 1)      e.hwdata = s.wdata[7:0] * 32'h01010101;
            else if (nb == 2) e.hwdata = s.wdata[15:0] * 32'h00010001;
            else              e.hwdata = s.wdata;
        end
        return e;
    endfunction

    task automatic idle_inputs();
        bus.cmd_valid = 1'b0;  bus.cmd_write = 1'b0;  bus.cmd_addr = 32'h0;
        bus.cmd_size  = 2'b00; bus.cmd_wdata = 32'h0; bus.rsp_ready = 1'b0;
        bus.HREADY    = 1'b1;  bus.HRESP = 1'b0;      bus.HRDATA = 32'h0;
    endtask

    task automatic do_reset();
        hreset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge hclk);
        hreset = 1'b0;
        @(negedge hclk);
    endtask

    // Runs one command from just after a negedge with the DUT idle; acts as slave.
    task automatic run(input vec_t v, input string tag);
        int aw_left, dw_left, nonseq, lat, budget;
        bit pending, in_data, got;
        aw_left = v.s.aw;  dw_left = v.s.dw;
        nonseq = 0;  lat = 0;  pending = 0;  got = 0;
        budget = 3 + v.s.aw + v.s.dw + 8;
        check({tag, " cmd_ready before"}, 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;  bus.cmd_write = v.s.write;  bus.cmd_addr = v.s.addr;
        bus.cmd_size  = v.s.size;  bus.cmd_wdata = v.s.wdata;  bus.rsp_ready = 1'b0;
        for (int k = 1; k <= budget && !got; k++) begin
            @(negedge hclk);
            if (k == 1) bus.cmd_valid = 1'b0;
            bus.HREADY = 1'b1;  bus.HRESP = 1'b0;  bus.HRDATA = $urandom;
            in_data = pending;
            pending = 0;
            if (bus.rsp_valid) begin
                got = 1;
                lat = k;
            end else if (bus.HTRANS == 2'b10) begin
                nonseq++;
                check({tag, " HADDR"}, bus.HADDR, v.s.addr);
                check({tag, " HSIZE"}, 32'(bus.HSIZE), {30'h0, v.s.size});
                check({tag, " HWRITE"}, 32'(bus.HWRITE), 32'(v.s.write));
                if (aw_left > 0) begin
                    bus.HREADY = 1'b0;
                    aw_left--;
                end else begin
                    pending = 1;
                end
            end else if (in_data) begin
                if (v.s.write) check({tag, " HWDATA"}, bus.HWDATA, v.e.hwdata);
                if (dw_left > 0) begin
                    bus.HREADY = 1'b0;
                    bus.HRESP  = v.s.err && (dw_left == 1);
                    dw_left--;
                    pending = 1;
                end else begin
                    bus.HRESP  = v.s.err;
                    bus.HRDATA = v.s.hrdata;
                end
            end
        end
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s rsp_valid wait: got none within %0d cycles expected at %0d", tag, budget, v.e.lat);
            do_reset();
            return;
        end
        bus.HREADY = 1'b1;  bus.HRESP = 1'b0;
        check({tag, " latency"}, 32'(lat), 32'(v.e.lat));
        check({tag, " rsp_err"}, 32'(bus.rsp_err), 32'(v.e.err));
        check({tag, " rsp_rdata"}, bus.rsp_rdata, v.e.rdata);
        check({tag, " rsp_timeout"}, 32'(bus.rsp_timeout), 32'(v.e.timeout));
        for (int h = 0; h < v.s.hold; h++) begin
            bus.rsp_ready = 1'b0;
            @(negedge hclk);
            if (bus.HTRANS == 2'b10) nonseq++;
            check({tag, " hold rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
            check({tag, " hold cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
            check({tag, " hold rsp_err"}, 32'(bus.rsp_err), 32'(v.e.err));
            check({tag, " hold rsp_rdata"}, bus.rsp_rdata, v.e.rdata);
            check({tag, " hold rsp_timeout"}, 32'(bus.rsp_timeout), 32'(v.e.timeout));
        end
        bus.rsp_ready = 1'b1;
        @(negedge hclk);
        bus.rsp_ready = 1'b0;
        if (bus.HTRANS == 2'b10) nonseq++;
        check({tag, " nonseq count"}, 32'(nonseq), 32'(v.e.nonseq));
        check({tag, " back idle cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        check({tag, " back idle rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    vec_t tbl[16];

    initial begin
        vec_t  v;
        stim_t s;
        n_cmp  = 0;
        n_fail = 0;

        //            w   addr          sz     wdata         aw dw er hrdata        hold lat ns err rdata        to hwdata
        tbl[0]  = mk(0, 32'h2000_0004, 2'b10, 32'h0,        0, 0, 0, 32'hDEADBEEF, 0,   3,  1, 0, 32'hDEADBEEF, 0, 32'h0);
        tbl[1]  = mk(1, 32'h4000_0003, 2'b00, 32'h0000_00A5,0, 3, 0, 32'h0,        0,   6,  1, 0, 32'h0,        0, 32'hA5A5A5A5);
        tbl[2]  = mk(0, 32'h1000_0002, 2'b01, 32'h0,        0, 0, 0, 32'h1234ABCD, 0,   3,  1, 0, 32'h00001234, 0, 32'h0);
        tbl[3]  = mk(0, 32'h1000_0001, 2'b01, 32'h0,        0, 0, 0, 32'h1234ABCD, 0,   1,  0, 1, 32'h0,        0, 32'h0);
        tbl[4]  = mk(0, 32'h3000_0000, 2'b10, 32'h0,        0, 1, 1, 32'h5555AAAA, 5,   4,  1, 1, 32'h0,        0, 32'h0);
        tbl[5]  = mk(0, 32'h5000_0008, 2'b10, 32'h0,        0, 20,0, 32'hCAFEF00D, 0,   23, 1, 0, 32'hCAFEF00D, 1, 32'h0);
        tbl[6]  = mk(0, 32'h5000_0008, 2'b10, 32'h0,        0, 0, 0, 32'h0BADC0DE, 0,   3,  1, 0, 32'h0BADC0DE, 0, 32'h0);
        tbl[7]  = mk(0, 32'h1000_0001, 2'b00, 32'h0,        0, 0, 0, 32'h1234ABCD, 0,   3,  1, 0, 32'h000000AB, 0, 32'h0);
        tbl[8]  = mk(1, 32'h0000_0000, 2'b11, 32'h12345678, 0, 0, 0, 32'h0,        1,   1,  0, 1, 32'h0,        0, 32'h0);
        tbl[9]  = mk(0, 32'h6000_0002, 2'b10, 32'h0,        0, 0, 0, 32'hFFFFFFFF, 0,   1,  0, 1, 32'h0,        0, 32'h0);
        tbl[10] = mk(1, 32'h7000_0002, 2'b01, 32'h1234BEEF, 2, 0, 0, 32'h0,        0,   5,  3, 0, 32'h0,        0, 32'hBEEFBEEF);
        tbl[11] = mk(0, 32'h9000_0000, 2'b10, 32'h0,        0, 15,0, 32'h11112222, 0,   18, 1, 0, 32'h11112222, 0, 32'h0);
        tbl[12] = mk(0, 32'h9000_0000, 2'b10, 32'h0,        0, 16,0, 32'h33334444, 0,   19, 1, 0, 32'h33334444, 1, 32'h0);
        tbl[13] = mk(0, 32'h1000_0003, 2'b00, 32'h0,        0, 0, 0, 32'h1234ABCD, 0,   3,  1, 0, 32'h00000012, 0, 32'h0);
        tbl[14] = mk(1, 32'h8000_0000, 2'b10, 32'h89ABCDEF, 1, 1, 1, 32'h0,        2,   5,  2, 1, 32'h0,        0, 32'h89ABCDEF);
        tbl[15] = mk(0, 32'h1000_0000, 2'b00, 32'h0,        0, 0, 0, 32'h1234ABCD, 0,   3,  1, 0, 32'h000000CD, 0, 32'h0);

        hreset = 1'b1;
        idle_inputs();
        repeat (3) @(negedge hclk);
        check("reset HTRANS", 32'(bus.HTRANS), 32'd0);
        check("reset HADDR", bus.HADDR, 32'h0);
        check("reset HWRITE", 32'(bus.HWRITE), 32'd0);
        check("reset HSIZE", 32'(bus.HSIZE), 32'd0);
        check("reset HWDATA", bus.HWDATA, 32'h0);
        check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset rsp_rdata", bus.rsp_rdata, 32'h0);
        check("reset rsp_err", 32'(bus.rsp_err), 32'd0);
        check("reset rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
        check("HBURST", 32'(bus.HBURST), 32'd0);
        check("HPROT", 32'(bus.HPROT), 32'h3);
        check("HMASTLOCK", 32'(bus.HMASTLOCK), 32'd0);
        hreset = 1'b0;
        @(negedge hclk);
        check("cmd_ready after reset", 32'(bus.cmd_ready), 32'd1);

        for (int i = 0; i < 16; i++) run(tbl[i], $sformatf("vec%0d", i));

        // Reset while the data phase is waiting on the slave.
        bus.cmd_valid = 1'b1;  bus.cmd_write = 1'b0;  bus.cmd_addr = 32'hA000_0010;
        bus.cmd_size  = 2'b10; bus.cmd_wdata = 32'h0;
        @(negedge hclk);
        bus.cmd_valid = 1'b0;
        check("midrst addr phase", 32'(bus.HTRANS), 32'h2);
        bus.HREADY = 1'b1;
        @(negedge hclk);
        check("midrst data phase", 32'(bus.HTRANS), 32'h0);
        bus.HREADY = 1'b0;
        @(negedge hclk);
        bus.HREADY = 1'b0;
        hreset = 1'b1;
        @(negedge hclk);
        check("midrst HTRANS", 32'(bus.HTRANS), 32'h0);
        check("midrst rsp_valid", 32'(bus.rsp_valid), 32'd0);
        hreset = 1'b0;
        bus.HREADY = 1'b1;
        @(negedge hclk);
        check("midrst cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("midrst rsp_valid after", 32'(bus.rsp_valid), 32'd0);
        run(tbl[0], "post-reset");
        run(tbl[1], "post-reset-wr");

        // Random commands against the reference model.
        for (int i = 0; i < 60; i++) begin
            s.write  = 1'($urandom_range(0, 1));
            s.addr   = $urandom;
            s.size   = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 8) begin
                s.size = 2'($urandom_range(0, 2));
                s.addr = s.addr & ~((32'd1 << s.size) - 32'd1);
            end
            s.wdata  = $urandom;
            s.aw     = $urandom_range(0, 3);
            s.dw     = ($urandom_range(0, 5) == 0) ? int'($urandom_range(14, 18)) : int'($urandom_range(0, 4));
            s.err    = ($urandom_range(0, 4) == 0);
            if (s.err && s.dw == 0) s.dw = 1;
            s.hrdata = $urandom;
            s.hold   = $urandom_range(0, 2);
            v.s = s;
            v.e = model(s);
            run(v, $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ahblite_single_master.md
# ahblite_single_master

Simple-command to AHB-Lite initiator: accepts one read/write command at a time on a valid/ready interface and runs it as a single NONSEQ transfer on the AHB-Lite bus. It handles:
- slave wait states and two-cycle ERROR responses;
- byte-lane replication on writes and lane extraction on reads;
- local rejection of illegal or misaligned commands.

It is the initiator-side counterpart of the interconnect's slave response mux, and drives HADDR/HTRANS into the decoder and slave ports.

## Interface
- TIMEOUT_CYCLES, 16, data-phase wait-state count (HREADY low) at or above which rsp_timeout is flagged; legal 1..65535.
- HCLK  in  1  clock, all logic on rising edge
- HRESET  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  32  byte address
- cmd_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- cmd_wdata  in  32  write data, right-justified (bits [7:0] / [15:0] / [31:0])
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  32  read data, zero-extended and right-justified; 0 for writes and errors
- rsp_err  out  1  slave ERROR or local reject
- rsp_timeout  out  1  data phase waited >= TIMEOUT_CYCLES
- HADDR  out  32, HTRANS  out  2, HWRITE  out  1, HSIZE  out  3, HBURST  out  3 (always 000), HPROT  out  4 (always 0011), HMASTLOCK  out  1 (always 0), HWDATA  out  32
- HREADY  in  1, HRESP  in  1, HRDATA  in  32

## Operation

**States:** IDLE, ADDR, DATA, RESP. All bus and rsp outputs are registered.

**IDLE**
- cmd_ready=1, HTRANS=00.
- On cmd_valid&cmd_ready, capture the command.
- Illegal command (size 11, halfword with addr[0]=1, or word with addr[1:0]!=0): go to RESP with rsp_err=1 and rsp_rdata=0. No bus activity.
- Otherwise go to ADDR.

**ADDR**
- Drives HTRANS=10 (NONSEQ), HADDR=cmd_addr, HWRITE, HSIZE={0,cmd_size}.
- Stays in ADDR while HREADY=0; all address signals are held stable.
- On HREADY=1, go to DATA.

**DATA**
- HTRANS=00. HWDATA holds the replicated write data: byte → {4{wdata[7:0]}}, half → {2{wdata[15:0]}}, word → wdata.
- Each cycle with HREADY=0 increments the wait counter, saturating at TIMEOUT_CYCLES.
- On HREADY=1:
  - rsp_err=HRESP.
  - For reads with HRESP=0, rsp_rdata = selected lane zero-extended: byte → HRDATA[8*addr[1:0]+:8], half → HRDATA[16*addr[1]+:16].
  - rsp_timeout = (count == TIMEOUT_CYCLES).
  - Go to RESP.
- ERROR first cycle (HRESP=1, HREADY=0): no action, keep waiting. The block never issues a new transfer during an ERROR, so no cancellation is needed.
- The block never abandons a data phase; timeout is status only.

**RESP**
- rsp_valid=1; all rsp fields held stable until rsp_ready=1.
- On rsp_valid&rsp_ready, go to IDLE, clear rsp_valid, and clear the wait counter.
- cmd_ready=0.

**Reset** (any state, including mid-transfer): next state IDLE. Reset values:
- HTRANS=00, HADDR=0, HWRITE=0, HSIZE=000, HWDATA=0
- rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0
- wait counter=0
- cmd_ready=1 in the first cycle after HRESET deasserts.

## Timing
- Accept at cycle N; ADDR (NONSEQ visible) in cycle N+1.
- Zero-wait slave: DATA in N+2, rsp_valid in N+3.
- Each HREADY=0 cycle in ADDR or DATA adds one cycle.
- Local reject: rsp_valid at N+1.
- Return to IDLE is one cycle after the rsp handshake. Minimum spacing is 4 cycles per bus command when rsp_ready=1.
- HWDATA is valid during the whole DATA state.
- HADDR/HWRITE/HSIZE are don't-care outside ADDR; they hold their last value.

## Test plan
- **Word read, zero wait:** cmd addr 0x2000_0004 size 10 read with HRDATA=0xDEADBEEF → one NONSEQ in cycle N+1, rsp_valid at N+3, rsp_rdata=0xDEADBEEF, rsp_err=0.
- **Byte write with waits:** addr 0x4000_0003, size 00, wdata 0xA5, slave HREADY low 3 DATA cycles → HWDATA=0xA5A5A5A5 held 4 cycles, HSIZE=000, rsp_valid at N+6, rsp_timeout=0.
- **Halfword read lane extraction:** addr 0x...02, HRDATA=0x1234ABCD → rsp_rdata=0x00001234. Addr 0x...01 halfword → rsp_err=1 at N+1 with no NONSEQ.
- **ERROR response:** HRESP=1/HREADY=0 then HRESP=1/HREADY=1 → rsp_err=1, rsp_rdata=0, no second NONSEQ issued. Also hold rsp_ready=0 for 5 cycles → rsp fields stable and cmd_ready=0 throughout.
- **Timeout:** TIMEOUT_CYCLES=16, HREADY low 20 DATA cycles → counter saturates at 16, transfer completes normally, rsp_timeout=1. A following zero-wait transfer → rsp_timeout=0.
- **Reset mid-DATA:** assert HRESET while in DATA → next cycle HTRANS=00, rsp_valid=0, cmd_ready=1 after deassert. A new command then completes correctly.
